pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Parametrised stall/flush controller for the in-order CPU pipeline; successor to the fixed 4-register stall chain.
- Takes per-stage stall requests plus one branch/exception flush request, and drives per-register hold, bubble and flush controls and a PC redirect strobe.
- Adds a pending-flush FSM that carries a flush across rdy-low cycles.
- Adds saturating per-register stall-cycle performance counters.
- Sits beside the pipeline registers: register 0 = PC, register NSTAGE-1 = last inter-stage register.

Parameters:
NSTAGE, 5, number of pipeline registers controlled (>=2)
CNT_W, 16, width of each stall-cycle counter
SW, $clog2(NSTAGE), stage-index width (localparam, not overridable)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; 0 freezes the whole pipeline
stall_req  in  NSTAGE  bit i: stage feeding register i cannot accept/advance
flush_valid  in  1  flush request this cycle
flush_stage  in  SW  oldest register to kill; registers 0..flush_stage are flushed
hold  out  NSTAGE  bit i: register i keeps its value
bubble  out  NSTAGE  bit i: register i loads a NOP/invalid
flush  out  NSTAGE  bit i: register i cleared to NOP (flush kill)
redirect  out  1  PC takes branch/trap target this cycle
flush_pending  out  1  a flush is latched awaiting rdy
cnt_clr  in  1  synchronous clear of all counters
cnt_sel  in  SW  counter select
cnt_value  out  CNT_W  counter[cnt_sel]; 0 if cnt_sel >= NSTAGE

Behaviour:
- All outputs combinational from inputs and state (zero latency), except counters and the pending FSM.
- While rst=0: state IDLE, pending stage 0, all counters 0, hold all-ones, bubble/flush/redirect 0, flush_pending 0.
- Base hold chain:
  - h[NSTAGE-1] = !rdy | stall_req[NSTAGE-1]
  - h[i] = !rdy | stall_req[i] | h[i+1]
- Base bubble: bubble[0]=0; bubble[i] = h[i-1] & !h[i] for i>=1.
- Flush stage clamp: any stage index >= NSTAGE is treated as NSTAGE-1.
- Pending FSM, states IDLE and PEND, with register pstage:
  - IDLE, flush_valid & !rdy: go PEND, pstage <= clamp(flush_stage).
  - PEND, !rdy, flush_valid: pstage <= max(pstage, clamp(flush_stage)); the older instruction's flush wins.
  - PEND, rdy: apply the flush, go IDLE.
  - IDLE, flush_valid & rdy: apply immediately; no state change.
- flush_pending = (state==PEND).
- Flush application in cycle with rdy=1 and (flush_valid or PEND):
  - S = max of pstage (if PEND) and clamp(flush_stage) (if flush_valid).
  - flush[i]=1 for i<=S; for those i, hold[i] and bubble[i] are forced 0.
  - Registers i>S keep base hold/bubble.
  - redirect=1.
- Without flush application: flush=0, redirect=0, hold=h, bubble=base.
- rdy=0: hold all-ones, bubble/flush/redirect 0 regardless of requests.
- Counters:
  - cnt[i] increments when rdy=1 & h[i]=1 & flush[i]=0.
  - Saturates at 2^CNT_W-1, never wraps.
  - cnt_clr=1 clears all counters that cycle; clear wins over increment.
- Reset asserted mid-PEND drops the pending flush; no redirect is issued after reset release.

Test Plan:
- NSTAGE=5, rdy=1, stall_req=5'b01000 -> hold=5'b01111, bubble=5'b10000, redirect=0; cnt[3] advances 1 per cycle, cnt[4]=0.
- rdy=1, stall_req=0, flush_valid=1, flush_stage=2 -> flush=5'b00111, hold=0, bubble=0, redirect=1 same cycle; flush_pending stays 0.
- rdy=0, flush_valid=1, flush_stage=1; next cycle rdy=0, flush_valid=1, flush_stage=3; then rdy=1, flush_valid=0 -> flush_pending=1 for 2 cycles, then flush=5'b01111, redirect=1 for 1 cycle, flush_pending=0.
- stall_req=5'b10000 with flush_valid=1, flush_stage=1, rdy=1 -> flush=5'b00011, hold=5'b11100, bubble=0, redirect=1.
- CNT_W=4, stall_req[0]=1 held 20 cycles -> cnt_sel=0 reads 15 (saturated). Pulsing cnt_clr together with a stall cycle reads 0 next cycle. cnt_sel=7 -> cnt_value=0.
- Enter PEND (rdy=0, flush_valid=1); drop rst for 1 cycle; release with rdy=1, flush_valid=0 -> flush_pending=0, redirect=0, all counters 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Stall/flush controller for the in-order CPU pipeline. Register 0 is the
//   PC and register NSTAGE-1 is the last inter-stage register. It turns
//   per-stage stall requests and a branch/exception flush request into
//   per-register hold, bubble and flush controls plus a PC redirect strobe.
//   A flush that arrives while the pipeline is frozen (rdy=0) is latched and
//   applied on the first ready cycle. Each register also has a saturating
//   stall-cycle counter that can be read back.
//
// Ports
//   clk           in   system clock, all state on the rising edge
//   rst           in   asynchronous active-low reset
//   rdy           in   global ready, 0 freezes the whole pipeline
//   stall_req     in   [NSTAGE] bit i: the stage feeding register i cannot advance
//   flush_valid   in   flush request this cycle
//   flush_stage   in   [SW] oldest register to kill (registers 0..flush_stage)
//   hold          out  [NSTAGE] register i keeps its value
//   bubble        out  [NSTAGE] register i loads a NOP
//   flush         out  [NSTAGE] register i is cleared by a flush kill
//   redirect      out  PC takes the branch/trap target this cycle
//   flush_pending out  a flush is latched and waiting for rdy
//   cnt_clr       in   synchronous clear of all stall counters
//   cnt_sel       in   [SW] stall counter select
//   cnt_value     out  [CNT_W] selected counter, 0 when cnt_sel is out of range

module pipe_stall_ctrl #(
    parameter  int NSTAGE = 5,
    parameter  int CNT_W  = 16,
    localparam int SW     = $clog2(NSTAGE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_valid,
    input  logic [SW-1:0]     flush_stage,
    output logic [NSTAGE-1:0] hold,
    output logic [NSTAGE-1:0] bubble,
    output logic [NSTAGE-1:0] flush,
    output logic              redirect,
    output logic              flush_pending,
    input  logic              cnt_clr,
    input  logic [SW-1:0]     cnt_sel,
    output logic [CNT_W-1:0]  cnt_value
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state;
    logic [SW-1:0]     pstage;
    logic [SW-1:0]     fs_clamped;
    logic [SW-1:0]     flush_sel;
    logic              apply;
    logic [NSTAGE-1:0] base_hold;
    logic [NSTAGE-1:0] base_bubble;
    logic [NSTAGE-1:0] flush_mask;
    logic [CNT_W-1:0]  cnt [NSTAGE];

    // Out-of-range flush stages kill the whole pipeline.
    always_comb begin
        fs_clamped = flush_stage;
        if (int'(flush_stage) >= NSTAGE) begin
            fs_clamped = SW'(NSTAGE - 1);
        end
    end

    // A stall propagates backwards: register i holds if any younger-side
    // stage from i upward stalls, or the whole pipe is frozen.
    always_comb begin
        logic acc;
        acc = !rdy;
        base_hold = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc = acc | stall_req[i];
            base_hold[i] = acc;
        end
    end

    // A register gets a bubble when the one behind it holds but it does not.
    always_comb begin
        base_bubble = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            base_bubble[i] = base_hold[i-1] & !base_hold[i];
        end
    end

    // The flush reaching the furthest (oldest) register wins between a
    // latched flush and a new request.
    always_comb begin
        apply = rst && rdy && (flush_valid || (state == PEND));
        flush_sel = '0;
        if (state == PEND) begin
            flush_sel = pstage;
        end
        if (flush_valid && (fs_clamped > flush_sel)) begin
            flush_sel = fs_clamped;
        end
        flush_mask = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            flush_mask[i] = apply && (SW'(i) <= flush_sel);
        end
    end

    // While in reset the pipeline is held frozen with no kills or redirects.
    always_comb begin
        hold          = '1;
        bubble        = '0;
        flush         = '0;
        redirect      = 1'b0;
        flush_pending = (state == PEND);
        if (rst) begin
            hold     = base_hold & ~flush_mask;
            bubble   = base_bubble & ~flush_mask;
            flush    = flush_mask;
            redirect = apply;
        end
    end

    // Pending-flush FSM: carries a flush across frozen cycles and merges
    // further requests so the oldest kill point survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pstage <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_valid && !rdy) begin
                        state  <= PEND;
                        pstage <= fs_clamped;
                    end
                end
                PEND: begin
                    if (rdy) begin
                        state <= IDLE;
                    end else if (flush_valid && (fs_clamped > pstage)) begin
                        pstage <= fs_clamped;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall-cycle counters count real hold cycles only: frozen cycles and
    // flushed registers do not count. They stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTAGE; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                if (cnt_clr) begin
                    cnt[i] <= '0;
                end else if (rdy && base_hold[i] && !flush_mask[i] && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter read mux, zero for selects beyond the last register.
    always_comb begin
        cnt_value = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (cnt_sel == SW'(i)) begin
                cnt_value = cnt[i];
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
//   Scoreboard bench for pipe_stall_ctrl with NSTAGE=5 and CNT_W=4. Each
//   step drives one cycle of inputs after the falling clock edge, queues the
//   expected outputs for that cycle and compares them shortly afterwards.

module tb_pipe_stall_ctrl;

    localparam int NSTAGE = 5;
    localparam int CNT_W  = 4;
    localparam int SW     = $clog2(NSTAGE);

    logic              clk;
    logic              rst;
    logic              rdy;
    logic [NSTAGE-1:0] stall_req;
    logic              flush_valid;
    logic [SW-1:0]     flush_stage;
    logic [NSTAGE-1:0] hold;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              redirect;
    logic              flush_pending;
    logic              cnt_clr;
    logic [SW-1:0]     cnt_sel;
    logic [CNT_W-1:0]  cnt_value;

    typedef struct {
        logic [NSTAGE-1:0] hold;
        logic [NSTAGE-1:0] bubble;
        logic [NSTAGE-1:0] flush;
        logic              redirect;
        logic              pending;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pipe_stall_ctrl #(
        .NSTAGE(NSTAGE),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_req    (stall_req),
        .flush_valid  (flush_valid),
        .flush_stage  (flush_stage),
        .hold         (hold),
        .bubble       (bubble),
        .flush        (flush),
        .redirect     (redirect),
        .flush_pending(flush_pending),
        .cnt_clr      (cnt_clr),
        .cnt_sel      (cnt_sel),
        .cnt_value    (cnt_value)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, queues the expected outputs, then pops and
    // compares them once the combinational outputs have settled.
    task automatic applyStimulus(
        input string             tag,
        input logic              r,
        input logic              rd,
        input logic [NSTAGE-1:0] st,
        input logic              fv,
        input logic [SW-1:0]     fs,
        input logic              clr,
        input logic [SW-1:0]     sel,
        input logic [NSTAGE-1:0] e_hold,
        input logic [NSTAGE-1:0] e_bubble,
        input logic [NSTAGE-1:0] e_flush,
        input logic              e_redirect,
        input logic              e_pending,
        input logic [CNT_W-1:0]  e_cnt
    );
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst         = r;
        rdy         = rd;
        stall_req   = st;
        flush_valid = fv;
        flush_stage = fs;
        cnt_clr     = clr;
        cnt_sel     = sel;
        e.hold      = e_hold;
        e.bubble    = e_bubble;
        e.flush     = e_flush;
        e.redirect  = e_redirect;
        e.pending   = e_pending;
        e.cnt       = e_cnt;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        checkOutput({tag, ".hold"},     32'(hold),          32'(got.hold));
        checkOutput({tag, ".bubble"},   32'(bubble),        32'(got.bubble));
        checkOutput({tag, ".flush"},    32'(flush),         32'(got.flush));
        checkOutput({tag, ".redirect"}, 32'(redirect),      32'(got.redirect));
        checkOutput({tag, ".pending"},  32'(flush_pending), 32'(got.pending));
        checkOutput({tag, ".cnt"},      32'(cnt_value),     32'(got.cnt));
    endtask

    initial begin
        rst         = 1'b0;
        rdy         = 1'b0;
        stall_req   = '0;
        flush_valid = 1'b0;
        flush_stage = '0;
        cnt_clr     = 1'b0;
        cnt_sel     = '0;

        // In reset a flush request must be ignored and everything held.
        applyStimulus("reset", 0, 1, 5'b00000, 1, 3'd2, 0, 3'd0,
                      5'b11111, 5'b00000, 5'b00000, 0, 0, 4'd0);

        // Stall at stage 3: registers 0..3 hold, register 4 gets a bubble.
        applyStimulus("stall3_a", 1, 1, 5'b01000, 0, 3'd0, 0, 3'd3,
                      5'b01111, 5'b10000, 5'b00000, 0, 0, 4'd0);
        applyStimulus("stall3_b", 1, 1, 5'b01000, 0, 3'd0, 0, 3'd3,
                      5'b01111, 5'b10000, 5'b00000, 0, 0, 4'd1);
        applyStimulus("stall3_c", 1, 1, 5'b01000, 0, 3'd0, 0, 3'd3,
                      5'b01111, 5'b10000, 5'b00000, 0, 0, 4'd2);
        applyStimulus("stall3_cnt4", 1, 1, 5'b01000, 0, 3'd0, 0, 3'd4,
                      5'b01111, 5'b10000, 5'b00000, 0, 0, 4'd0);

        // Immediate flush of registers 0..2.
        applyStimulus("flush_now", 1, 1, 5'b00000, 1, 3'd2, 0, 3'd3,
                      5'b00000, 5'b00000, 5'b00111, 1, 0, 4'd4);
        applyStimulus("after_flush", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd3,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd4);

        // Flush latched while frozen; the older kill point (3) must win.
        applyStimulus("pend_enter", 1, 0, 5'b00000, 1, 3'd1, 0, 3'd3,
                      5'b11111, 5'b00000, 5'b00000, 0, 0, 4'd4);
        applyStimulus("pend_merge", 1, 0, 5'b00000, 1, 3'd3, 0, 3'd3,
                      5'b11111, 5'b00000, 5'b00000, 0, 1, 4'd4);
        applyStimulus("pend_younger", 1, 0, 5'b00000, 1, 3'd0, 0, 3'd3,
                      5'b11111, 5'b00000, 5'b00000, 0, 1, 4'd4);
        applyStimulus("pend_apply", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd3,
                      5'b00000, 5'b00000, 5'b01111, 1, 1, 4'd4);
        applyStimulus("pend_done", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd3,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd4);

        // Flush combined with a stall on the last register.
        applyStimulus("flush_stall", 1, 1, 5'b10000, 1, 3'd1, 0, 3'd4,
                      5'b11100, 5'b00000, 5'b00011, 1, 0, 4'd0);
        // Out-of-range flush stage clamps to the last register.
        applyStimulus("flush_clamp", 1, 1, 5'b00000, 1, 3'd7, 0, 3'd4,
                      5'b00000, 5'b00000, 5'b11111, 1, 0, 4'd1);
        // Flush of register 0 only; registers above keep stall hold/bubble.
        applyStimulus("flush_s0", 1, 1, 5'b00100, 1, 3'd0, 0, 3'd2,
                      5'b00110, 5'b01000, 5'b00001, 1, 0, 4'd5);
        applyStimulus("cnt2_read", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd2,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd6);

        // Counter 0 starts at 4 and must stick at 15.
        for (int k = 0; k < 20; k++) begin
            applyStimulus($sformatf("sat_%0d", k), 1, 1, 5'b00001, 0, 3'd0, 0, 3'd0,
                          5'b00001, 5'b00010, 5'b00000, 0, 0,
                          4'((4 + k > 15) ? 15 : 4 + k));
        end

        // Clear wins over a same-cycle increment.
        applyStimulus("clr", 1, 1, 5'b00001, 0, 3'd0, 1, 3'd0,
                      5'b00001, 5'b00010, 5'b00000, 0, 0, 4'd15);
        applyStimulus("after_clr", 1, 1, 5'b00001, 0, 3'd0, 0, 3'd0,
                      5'b00001, 5'b00010, 5'b00000, 0, 0, 4'd0);
        applyStimulus("sel_oob", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd7,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd0);
        applyStimulus("sel0", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd0,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd1);

        // Reset during a pending flush drops it for good.
        applyStimulus("rpend_enter", 1, 0, 5'b00000, 1, 3'd2, 0, 3'd0,
                      5'b11111, 5'b00000, 5'b00000, 0, 0, 4'd1);
        applyStimulus("rpend_wait", 1, 0, 5'b00000, 0, 3'd0, 0, 3'd0,
                      5'b11111, 5'b00000, 5'b00000, 0, 1, 4'd1);
        applyStimulus("rpend_reset", 0, 0, 5'b00000, 0, 3'd0, 0, 3'd0,
                      5'b11111, 5'b00000, 5'b00000, 0, 0, 4'd0);
        applyStimulus("rpend_release", 1, 1, 5'b00000, 0, 3'd0, 0, 3'd0,
                      5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd0);
        for (int s = 1; s < NSTAGE; s++) begin
            applyStimulus($sformatf("rpend_cnt%0d", s), 1, 1, 5'b00000, 0, 3'd0, 0, 3'(s),
                          5'b00000, 5'b00000, 5'b00000, 0, 0, 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
